// File: rtl/phy_rx_sync_deser.sv
// phy_rx_sync_deser: serial-to-parallel receiver for the phy_rx path (clk_32f domain).
// Bits arrive MSB first. The block hunts for a comma to find word boundaries and locks
// after LOCK_CNT consecutive aligned commas. Once locked, idle and comma symbols are
// dropped and each data word is presented with a one-cycle valid pulse.
module phy_rx_sync_deser #(
  parameter int unsigned  W        = 8,
  parameter logic [W-1:0] COMMA    = W'(8'hBC),
  parameter logic [W-1:0] IDLE     = W'(8'h7C),
  parameter int unsigned  LOCK_CNT = 4,
  parameter int unsigned  LOSS_CNT = 2,
  parameter int unsigned  MAX_GAP  = 64
) (
  input  logic         clk_32f,
  input  logic         reset_L,
  input  logic         data_in,
  output logic [W-1:0] data_out,
  output logic         valid_out,
  output logic         locked,
  output logic         sync_err
);

  localparam int unsigned BW = $clog2(W);
  localparam int unsigned CW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MW = $clog2(LOSS_CNT + 1);
  localparam int unsigned GW = $clog2(MAX_GAP + 2);

  localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
  localparam logic [CW-1:0] COMMA_LIM = CW'(LOCK_CNT);
  localparam logic [MW-1:0] MIS_LIM   = MW'(LOSS_CNT);
  localparam logic [GW-1:0] GAP_LIM   = GW'(MAX_GAP + 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Only W-1 history bits are needed; the incoming bit completes the window.
  logic [W-2:0]  sr_q, sr_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic [MW-1:0] mis_cnt_q, mis_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  logic [W-1:0]  data_out_q, data_out_d;
  logic          valid_out_q, valid_out_d;
  logic          locked_q, locked_d;
  logic          sync_err_q, sync_err_d;

  logic [W-1:0]  win_c;
  logic          bt_c;
  logic          is_comma_c;
  logic          is_idle_c;
  logic          loss_c;
  logic [BW-1:0] bit_cnt_inc_c;
  logic [CW-1:0] comma_inc_c;
  logic [MW-1:0] mis_inc_c;
  logic [GW-1:0] gap_inc_c;

  // Current symbol window, boundary flag and saturating counter increments.
  always_comb begin
    win_c         = {sr_q, data_in};
    bt_c          = (bit_cnt_q == BIT_LAST);
    is_comma_c    = (win_c == COMMA);
    is_idle_c     = (win_c == IDLE);
    bit_cnt_inc_c = bt_c ? '0 : bit_cnt_q + BW'(1);
    comma_inc_c   = (comma_cnt_q >= COMMA_LIM) ? COMMA_LIM : comma_cnt_q + CW'(1);
    mis_inc_c     = (mis_cnt_q >= MIS_LIM) ? MIS_LIM : mis_cnt_q + MW'(1);
    gap_inc_c     = (gap_cnt_q >= GAP_LIM) ? GAP_LIM : gap_cnt_q + GW'(1);
  end

  // State register.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter update: hunt, align confirmation and locked monitoring.
  always_comb begin
    state_d     = state_q;
    sr_d        = win_c[W-2:0];
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    loss_c      = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        bit_cnt_d = '0;
        if (is_comma_c) begin
          comma_cnt_d = CW'(1);
          mis_cnt_d   = '0;
          gap_cnt_d   = '0;
          state_d     = (LOCK_CNT == 1) ? ST_LOCKED : ST_ALIGN;
        end
      end

      ST_ALIGN: begin
        bit_cnt_d = bit_cnt_inc_c;
        if (bt_c) begin
          if (is_comma_c) begin
            comma_cnt_d = comma_inc_c;
            if (comma_inc_c >= COMMA_LIM) begin
              mis_cnt_d = '0;
              gap_cnt_d = '0;
              state_d   = ST_LOCKED;
            end
          end else begin
            comma_cnt_d = '0;
            bit_cnt_d   = '0;
            state_d     = ST_HUNT;
          end
        end
      end

      ST_LOCKED: begin
        bit_cnt_d = bit_cnt_inc_c;
        if (bt_c) begin
          if (is_comma_c) begin
            gap_cnt_d = '0;
            mis_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_inc_c;
          end
        end else if (is_comma_c) begin
          mis_cnt_d = mis_inc_c;
        end
        // Too many misaligned commas or too long without an aligned one.
        if ((mis_cnt_d >= MIS_LIM) || (gap_cnt_d >= GAP_LIM)) begin
          loss_c      = 1'b1;
          state_d     = ST_HUNT;
          bit_cnt_d   = '0;
          comma_cnt_d = '0;
          mis_cnt_d   = '0;
          gap_cnt_d   = '0;
        end
      end

      default: begin
        state_d     = ST_HUNT;
        bit_cnt_d   = '0;
        comma_cnt_d = '0;
        mis_cnt_d   = '0;
        gap_cnt_d   = '0;
      end
    endcase
  end

  // Output next values; a data word on the loss edge is still delivered.
  always_comb begin
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    locked_d    = (state_d == ST_LOCKED);
    sync_err_d  = loss_c;
    if ((state_q == ST_LOCKED) && bt_c && !is_comma_c && !is_idle_c) begin
      data_out_d  = win_c;
      valid_out_d = 1'b1;
    end
  end

  // Datapath and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      mis_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      locked_q    <= locked_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign locked    = locked_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_phy_rx_sync_deser.sv
// Bench for phy_rx_sync_deser: directed scenarios plus a random symbol stream,
// compared every bit against a bit-index based reference model.
module tb_phy_rx_sync_deser;

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_IDLE  = 8'h7C;

  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       locked;
  logic       sync_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_valid;
  int cnt_err;

  always #5 clk_32f = ~clk_32f;

  phy_rx_sync_deser #(
    .W(8), .COMMA(8'hBC), .IDLE(8'h7C), .LOCK_CNT(4), .LOSS_CNT(2), .MAX_GAP(64)
  ) dut (
    .clk_32f  (clk_32f),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .locked   (locked),
    .sync_err (sync_err)
  );

  // Reference model: word boundaries are tracked as absolute bit positions
  // relative to the bit index at which the first comma was seen.
  int         m_mode;      // 0 hunting, 1 confirming, 2 locked
  longint     m_idx;
  longint     m_anchor;
  int         m_commas, m_mis, m_gap;
  logic [7:0] m_win, m_data;
  logic       m_valid, m_lock, m_err;

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_anchor = 0;
    m_commas = 0; m_mis = 0; m_gap = 0;
    m_win = 8'h00; m_data = 8'h00;
    m_valid = 1'b0; m_lock = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic b);
    logic on_bnd;
    m_win   = {m_win[6:0], b};
    m_idx   = m_idx + 1;
    m_valid = 1'b0;
    m_err   = 1'b0;
    on_bnd  = (((m_idx - m_anchor) % 8) == 0);
    if (m_mode == 0) begin
      if (m_win == K_COMMA) begin
        m_anchor = m_idx; m_commas = 1; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (on_bnd) begin
        if (m_win == K_COMMA) begin
          m_commas++;
          if (m_commas == 4) begin m_mode = 2; m_mis = 0; m_gap = 0; end
        end else begin
          m_mode = 0; m_commas = 0;
        end
      end
    end else begin
      if (on_bnd) begin
        if (m_win == K_COMMA) begin
          m_gap = 0; m_mis = 0;
        end else begin
          m_gap++;
          if (m_win != K_IDLE) begin m_data = m_win; m_valid = 1'b1; end
        end
      end else if (m_win == K_COMMA) begin
        m_mis++;
      end
      if (m_mis >= 2 || m_gap > 64) begin
        m_mode = 0; m_err = 1'b1; m_commas = 0; m_mis = 0; m_gap = 0;
      end
    end
    m_lock = (m_mode == 2);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One serial bit: drive, clock, advance model, compare all outputs.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
    model_step(b);
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("locked",    32'(locked),    32'(m_lock));
    check("sync_err",  32'(sync_err),  32'(m_err));
    check("data_out",  32'(data_out),  32'(m_data));
    cnt_valid += int'(valid_out);
    cnt_err   += int'(sync_err);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    reset_L = 1'b0;
    model_reset();
    #1;
    check("rst_data_out",  32'(data_out),  32'h0);
    check("rst_valid_out", 32'(valid_out), 32'h0);
    check("rst_locked",    32'(locked),    32'h0);
    check("rst_sync_err",  32'(sync_err),  32'h0);
    @(negedge clk_32f);
    @(negedge clk_32f);
    reset_L = 1'b1;
  endtask

  logic [7:0]  gap_set [4];
  int unsigned r;
  int unsigned nslip;

  initial begin
    gap_set[0] = 8'h7C; gap_set[1] = 8'h11; gap_set[2] = 8'h22; gap_set[3] = 8'h44;
    model_reset();
    cnt_valid = 0; cnt_err = 0;
    #1;
    do_reset();

    // 1: four aligned commas lock on the last bit of the fourth
    cnt_valid = 0; cnt_err = 0;
    send_byte(K_COMMA); send_byte(K_COMMA); send_byte(K_COMMA);
    for (int i = 7; i >= 1; i--) send_bit(K_COMMA[i]);
    check("t1_not_yet_locked", 32'(locked), 32'h0);
    send_bit(K_COMMA[0]);
    check("t1_locked", 32'(locked), 32'h1);
    check("t1_no_valid", 32'(cnt_valid), 32'h0);
    check("t1_no_err", 32'(cnt_err), 32'h0);

    // 2: idles are dropped, the single data word is delivered
    cnt_valid = 0;
    for (int k = 0; k < 4; k++) send_byte(K_IDLE);
    send_byte(8'hFF);
    check("t2_valid_ff", 32'(valid_out), 32'h1);
    check("t2_data_ff", 32'(data_out), 32'hFF);
    for (int k = 0; k < 3; k++) send_byte(K_IDLE);
    check("t2_one_valid", 32'(cnt_valid), 32'h1);

    // 3: junk bits ahead of the commas; lock on the true boundary
    do_reset();
    cnt_valid = 0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int k = 0; k < 4; k++) send_byte(K_COMMA);
    check("t3_locked", 32'(locked), 32'h1);
    send_byte(8'hA5);
    check("t3_valid_a5", 32'(valid_out), 32'h1);
    check("t3_data_a5", 32'(data_out), 32'hA5);
    check("t3_one_valid", 32'(cnt_valid), 32'h1);

    // 4: a non-comma during alignment restarts the hunt
    do_reset();
    for (int k = 0; k < 3; k++) send_byte(K_COMMA);
    send_byte(8'h55);
    check("t4_unlocked", 32'(locked), 32'h0);
    for (int k = 0; k < 3; k++) send_byte(K_COMMA);
    check("t4_three_not_enough", 32'(locked), 32'h0);
    send_byte(K_COMMA);
    check("t4_relocked", 32'(locked), 32'h1);

    // 5: two commas one bit late force loss of sync
    cnt_err = 0;
    send_bit(1'b0);
    send_byte(K_COMMA);
    check("t5_still_locked", 32'(locked), 32'h1);
    send_byte(K_COMMA);
    check("t5_sync_err", 32'(sync_err), 32'h1);
    check("t5_unlocked", 32'(locked), 32'h0);
    check("t5_one_err", 32'(cnt_err), 32'h1);

    // 6: 65 words without an aligned comma exceed the allowed gap
    for (int k = 0; k < 4; k++) send_byte(K_COMMA);
    check("t6_locked", 32'(locked), 32'h1);
    cnt_err = 0;
    for (int k = 1; k <= 65; k++) begin
      send_byte(gap_set[$urandom_range(0, 3)]);
      if (k == 64) begin
        check("t6_no_err_64", 32'(cnt_err), 32'h0);
        check("t6_locked_64", 32'(locked), 32'h1);
      end
    end
    check("t6_sync_err_65", 32'(sync_err), 32'h1);
    check("t6_unlocked_65", 32'(locked), 32'h0);

    // 6b: reset mid-word clears outputs at once; relock needs fresh commas
    for (int k = 0; k < 4; k++) send_byte(K_COMMA);
    send_byte(8'hFF);
    check("t6b_pre_data", 32'(data_out), 32'hFF);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    do_reset();
    for (int k = 0; k < 3; k++) send_byte(K_COMMA);
    check("t6b_three_not_enough", 32'(locked), 32'h0);
    send_byte(K_COMMA);
    check("t6b_relocked", 32'(locked), 32'h1);

    // Random symbol stream with occasional bit slips
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        send_byte(K_COMMA);
      end else if (r < 6) begin
        send_byte(K_IDLE);
      end else if (r < 9) begin
        send_byte(8'($urandom));
      end else begin
        nslip = $urandom_range(1, 3);
        for (int k = 0; k < int'(nslip); k++) send_bit(1'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
